// File: rtl/alu24_pkg.sv
// Shared constants and state type for the 24-bit ALU control sequencer:
// MIPS ALU-control op codes, ALU mux select encodings and FSM states.
package alu24_pkg;

    localparam int W = 24;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SLT2 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [2:0] code);
        return (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) ||
               (code == OP_SUB) || (code == OP_SLT);
    endfunction

endpackage

// File: rtl/alu24_ctrl_seq.sv
// Operation sequencer driving an external 24-bit MIPS-style ALU slice; SLT takes two passes.
// Optional carry-out flag output `co` is enabled with `define ALU24_CARRY_OUT_EN.
module alu24_ctrl_seq
    import alu24_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         ovf,
    output logic         err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    output logic         alu_binv,
    output logic         alu_sel1,
    output logic         alu_sel0,
    output logic [W-1:0] alu_less,
    input  logic [W-1:0] alu_result,
    input  logic         alu_co,
`ifdef ALU24_CARRY_OUT_EN
    output logic         co,
`endif
    output logic [1:0]   state
);

    // Handshake: a request is taken on a rising edge where start=1 and ready=1;
    // done is high for exactly one cycle and result/zero/ovf/err are valid then.

    state_t         st;
    logic [W-1:0]   a_r, b_r;
    logic [2:0]     op_r;
    logic           set_r;
    logic           v_r;
    logic [1:0]     sel;
    logic           v_now;

    // Signed overflow of a + b' where b' is the (possibly inverted) B operand.
    function automatic logic add_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic inv, input logic [W-1:0] r);
        logic bs;
        bs = b[W-1] ^ inv;
        return (a[W-1] == bs) && (r[W-1] != a[W-1]);
    endfunction

`ifndef ALU24_CARRY_OUT_EN
    logic unused_co;
    assign unused_co = alu_co;
`endif

    assign state = st;
    assign ready = (st == ST_IDLE) || (st == ST_DONE);
    assign done  = (st == ST_DONE);
    assign v_now = add_ovf(a_r, b_r, alu_binv, alu_result);
    assign alu_sel1 = sel[1];
    assign alu_sel0 = sel[0];

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_binv = 1'b0;
        alu_less = '0;
        sel      = SEL_AND;
        case (st)
            ST_EXEC: begin
                alu_a = a_r;
                alu_b = b_r;
                case (op_r)
                    OP_OR:  sel = SEL_OR;
                    OP_ADD: sel = SEL_ADD;
                    OP_SUB, OP_SLT: begin
                        sel      = SEL_ADD;
                        alu_binv = 1'b1;
                        alu_cin  = 1'b1;
                    end
                    default: sel = SEL_AND;
                endcase
            end
            ST_SLT2: begin
                alu_a    = a_r;
                alu_b    = b_r;
                sel      = SEL_LESS;
                alu_less = {{(W-1){1'b0}}, set_r};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_AND;
            set_r  <= 1'b0;
            v_r    <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            ovf    <= 1'b0;
            err    <= 1'b0;
`ifdef ALU24_CARRY_OUT_EN
            co     <= 1'b0;
`endif
        end else begin
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r  <= a_in;
                        b_r  <= b_in;
                        op_r <= op;
                        if (is_legal(op)) begin
                            st <= ST_EXEC;
                        end else begin
                            // Illegal code skips the ALU and reports immediately.
                            st     <= ST_DONE;
                            result <= '0;
                            zero   <= 1'b1;
                            ovf    <= 1'b0;
                            err    <= 1'b1;
`ifdef ALU24_CARRY_OUT_EN
                            co     <= 1'b0;
`endif
                        end
                    end else begin
                        st <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (op_r == OP_SLT) begin
                        // Sign of a-b corrected for overflow gives the true a<b.
                        set_r <= alu_result[W-1] ^ v_now;
                        v_r   <= v_now;
                        st    <= ST_SLT2;
                    end else begin
                        result <= alu_result;
                        zero   <= (alu_result == '0);
                        ovf    <= (op_r == OP_ADD || op_r == OP_SUB) ? v_now : 1'b0;
                        err    <= 1'b0;
`ifdef ALU24_CARRY_OUT_EN
                        co     <= (op_r == OP_ADD || op_r == OP_SUB) ? alu_co : 1'b0;
`endif
                        st     <= ST_DONE;
                    end
                end
                ST_SLT2: begin
                    result <= alu_result;
                    zero   <= (alu_result == '0);
                    ovf    <= v_r;
                    err    <= 1'b0;
`ifdef ALU24_CARRY_OUT_EN
                    co     <= 1'b0;
`endif
                    st     <= ST_DONE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu24_ctrl_seq.sv
// Self-checking bench for alu24_ctrl_seq: behavioural ALU beside the DUT,
// arithmetic reference model feeding a scoreboard queue checked by a done monitor.
module tb_alu24_ctrl_seq;
    import alu24_pkg::*;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         ready, done, zero, ovf, err;
    logic [W-1:0] result, alu_a, alu_b, alu_less, alu_result;
    logic         alu_cin, alu_binv, alu_sel1, alu_sel0, alu_co;
    logic [1:0]   state;
`ifdef ALU24_CARRY_OUT_EN
    logic         co;
`endif

    alu24_ctrl_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .ready(ready), .done(done), .result(result), .zero(zero), .ovf(ovf), .err(err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_binv(alu_binv),
        .alu_sel1(alu_sel1), .alu_sel0(alu_sel0), .alu_less(alu_less),
        .alu_result(alu_result), .alu_co(alu_co),
`ifdef ALU24_CARRY_OUT_EN
        .co(co),
`endif
        .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    // Behavioural model of the external ALU slice.
    logic [W-1:0] bp;
    logic [W:0]   sum;
    always_comb begin
        bp  = alu_binv ? ~alu_b : alu_b;
        sum = {1'b0, alu_a} + {1'b0, bp} + {{W{1'b0}}, alu_cin};
        alu_co = sum[W];
        case ({alu_sel1, alu_sel0})
            2'b00:   alu_result = alu_a & bp;
            2'b01:   alu_result = alu_a | bp;
            2'b10:   alu_result = sum[W-1:0];
            default: alu_result = alu_less;
        endcase
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [W+2:0] exp_q[$];
    int           due_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    localparam int MAXS = (1 << (W-1)) - 1;
    localparam int MINS = -(1 << (W-1));

    // Expected {result, zero, ovf, err} from plain signed arithmetic.
    function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int d  = 0;
        logic [W-1:0] r = '0;
        logic v = 1'b0;
        logic e = 1'b0;
        case (o)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: begin r = a + b; d = sa + sb; v = (d > MAXS) || (d < MINS); end
            OP_SUB: begin r = a - b; d = sa - sb; v = (d > MAXS) || (d < MINS); end
            OP_SLT: begin
                r = {{(W-1){1'b0}}, (sa < sb)};
                d = sa - sb;
                v = (d > MAXS) || (d < MINS);
            end
            default: e = 1'b1;
        endcase
        return {r, (r == '0), v, e};
    endfunction

    function automatic int lat(input logic [2:0] o);
        if (o == OP_SLT) return 3;
        if (o == OP_AND || o == OP_OR || o == OP_ADD || o == OP_SUB) return 2;
        return 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W+2:0] e;
                int due;
                e   = exp_q.pop_front();
                due = due_q.pop_front();
                chk("result", result, e[W+2:3]);
                chk("zero",   zero,   e[2]);
                chk("ovf",    ovf,    e[1]);
                chk("err",    err,    e[0]);
                chk("done_cycle", cyc, due);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        exp_q.push_back(model(o, a, b));
        due_q.push_back(cyc + lat(o));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] codes [8];
        rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        codes = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, 3'b011, 3'b100, 3'b101};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  ready,  32'd1);
        chk("rst_done",   done,   32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero",   zero,   32'd1);
        chk("rst_ovf",    ovf,    32'd0);
        chk("rst_err",    err,    32'd0);
        chk("rst_state",  state,  32'd0);
        chk("rst_alu", 32'((|alu_a) | (|alu_b) | (|alu_less) | alu_cin | alu_binv
                           | alu_sel1 | alu_sel0), 32'd0);

        issue(OP_ADD, 24'h7FFFFF, 24'h000001);

        issue(OP_SUB, 24'h000005, 24'h000005);
        @(negedge clk);
        chk("sub_binv", alu_binv, 32'd1);
        chk("sub_cin",  alu_cin,  32'd1);

        issue(OP_SLT, 24'h800000, 24'h000001);
        @(negedge clk);
        @(negedge clk);
        chk("slt2_less", alu_less, 32'h000001);
        chk("slt2_sel",  {alu_sel1, alu_sel0}, 32'd3);

        issue(OP_SLT, 24'h7FFFFF, 24'hFFFFFF);
        issue(3'b011, 24'h123456, 24'h654321);

        // start raised while busy must be dropped, not queued.
        issue(OP_ADD, 24'h000010, 24'h000020);
        @(negedge clk);
        start = 1'b1; op = OP_OR; a_in = 24'hAAAAAA; b_in = 24'h555555;
        @(posedge clk);
        #1 start = 1'b0;

        // Reset in SLT2 aborts with no done pulse.
        issue(OP_SLT, 24'h000001, 24'h000002);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_slt2", state, 32'(ST_SLT2));
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(due_q.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_state",  state,  32'd0);
        chk("abort_ready",  ready,  32'd1);
        chk("abort_done",   done,   32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero",   zero,   32'd1);

        issue(OP_AND, 24'hF0F0F0, 24'hFF00FF);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 5) == 0) rb = ra;
            issue(codes[$urandom_range(0, 7)], ra, rb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
